serial_operand_feeder: RTL and testbench

SERIAL_OPERAND_FEEDER -- requirements
Module: serial_operand_feeder

---
 rtl/serial_operand_feeder.sv | 169 ++++++++++++++++
 tb/tb_serial_operand_feeder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_feeder.sv
// serial_operand_feeder
//
// Accepts a parallel operand pair (op_a, op_b) plus a carry-in through a
// valid/ready handshake and streams the operands out LSB first, one bit per
// cycle. Each frame is WIDTH data cycles followed by GAP idle slots.
//
// Parameters
//   WIDTH : operand width (serial bits per frame)
//   GAP   : idle slots after the last data bit of each frame (1..3)
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : asynchronous, active-high reset
//   in_valid    : upstream offers an operand pair
//   in_ready    : feeder accepts the pair this cycle (IDLE or final gap slot)
//   op_a, op_b  : parallel operands, held by upstream until accepted
//   cin         : carry-in belonging to the offered pair
//   a, b        : registered serial operand bits, LSB first
//   carryin     : captured cin, constant for the whole frame and after it
//   frame_start : one-cycle pulse coincident with bit 0 on a/b
//   busy        : high while data bits or gap slots are being presented
//   frames_sent : completed-frame counter, wraps modulo 256

module serial_operand_feeder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             a,
  output logic             b,
  output logic             carryin,
  output logic             frame_start,
  output logic             busy,
  output logic [7:0]       frames_sent
);

  // The counter must reach both WIDTH-1 (data) and GAP-1 (at most 2).
  localparam int unsigned CNT_W = ($clog2(WIDTH) > 2) ? $clog2(WIDTH) : 2;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             carry_q, carry_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             fs_q, fs_d;
  logic [7:0]       frames_q, frames_d;

  logic             last_gap;
  logic             accept;

  assign last_gap = (state_q == S_GAP) && (cnt_q == LAST_GAP);

  // Ready is forced low while reset is asserted even though the state
  // register already sits in IDLE.
  assign in_ready = !rst && ((state_q == S_IDLE) || last_gap);
  assign accept   = in_valid && in_ready;

  // Next-state and datapath.
  // The shift registers hold only the bits not yet presented: bit 0 goes
  // straight into the a/b output flops on accept, the rest are shifted
  // down one position per SHIFT cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_a_d   = sh_a_q;
    sh_b_d   = sh_b_q;
    carry_d  = carry_q;
    frames_d = frames_q;
    a_d      = 1'b0;
    b_d      = 1'b0;
    fs_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Wait for an accepted operand pair (handled below).
      end

      S_SHIFT: begin
        if (cnt_q == LAST_BIT) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          a_d    = sh_a_q[0];
          b_d    = sh_b_q[0];
          sh_a_d = sh_a_q >> 1;
          sh_b_d = sh_b_q >> 1;
        end
      end

      S_GAP: begin
        if (cnt_q == LAST_GAP) begin
          frames_d = frames_q + 8'd1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Accept can only happen in IDLE or the final gap slot, so it safely
    // overrides whatever the case above decided for those states.
    if (accept) begin
      state_d = S_SHIFT;
      cnt_d   = '0;
      a_d     = op_a[0];
      b_d     = op_b[0];
      sh_a_d  = op_a >> 1;
      sh_b_d  = op_b >> 1;
      carry_d = cin;
      fs_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      carry_q  <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      fs_q     <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      fs_q     <= fs_d;
      frames_q <= frames_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign frame_start = fs_q;
  assign carryin     = carry_q;
  assign busy        = (state_q != S_IDLE);
  assign frames_sent = frames_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Testbench for serial_operand_feeder.
// Expected serial frames are queued when an operand pair is accepted by the
// reference model; a monitor pops one record per busy cycle and compares.

module tb_serial_operand_feeder;

  localparam int unsigned W = 4;
  localparam int unsigned G = 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         a;
  logic         b;
  logic         carryin;
  logic         frame_start;
  logic         busy;
  logic [7:0]   frames_sent;

  serial_operand_feeder #(
    .WIDTH(W),
    .GAP  (G)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .cin        (cin),
    .a          (a),
    .b          (b),
    .carryin    (carryin),
    .frame_start(frame_start),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       fs;
    logic       c;
    logic [7:0] f;
  } rec_t;

  rec_t exp_q[$];

  int         n_cmp = 0;
  int         n_bad = 0;

  // Reference model: remaining busy cycles of the current frame (0 = idle),
  // completed frame count and last captured carry.
  int         mdl_rem    = 0;
  logic [7:0] mdl_frames = 8'd0;
  logic       mdl_carry  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check handshake/idle outputs, drive inputs, let the
  // model decide acceptance and advance its frame bookkeeping.
  task automatic cycle(input logic v, input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic xc, output logic acc);
    logic mdl_ready;
    logic [7:0] f_at;
    rec_t r;
    @(negedge clk);
    mdl_ready = !rst && (mdl_rem <= 1);
    check("in_ready", in_ready, mdl_ready);
    check("busy", busy, mdl_rem != 0);
    if (mdl_rem == 0) begin
      check("idle_outs", {a, b, frame_start}, 3'b000);
      check("idle_frames", frames_sent, mdl_frames);
      check("idle_carry", carryin, mdl_carry);
    end
    in_valid = v;
    op_a     = xa;
    op_b     = xb;
    cin      = xc;
    acc      = v && mdl_ready;
    if (acc) begin
      f_at = mdl_frames + ((mdl_rem == 1) ? 8'd1 : 8'd0);
      for (int k = 0; k < int'(W + G); k++) begin
        r.a  = (k < int'(W)) ? xa[k] : 1'b0;
        r.b  = (k < int'(W)) ? xb[k] : 1'b0;
        r.fs = (k == 0);
        r.c  = xc;
        r.f  = f_at;
        exp_q.push_back(r);
      end
      mdl_carry = xc;
    end
    if (mdl_rem == 1) mdl_frames = mdl_frames + 8'd1;
    if (acc)              mdl_rem = W + G;
    else if (mdl_rem > 0) mdl_rem = mdl_rem - 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    mdl_rem    = 0;
    mdl_frames = 8'd0;
    mdl_carry  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every busy cycle must match the next queued record.
  always @(negedge clk) begin
    rec_t r;
    if (!rst && busy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame_out: busy with no expected record at %0t", $time);
      end else begin
        r = exp_q.pop_front();
        check("frame_out", {a, b, frame_start, carryin, frames_sent}, r);
      end
    end
  end

  initial begin
    logic         acc;
    logic [W-1:0] pa, pb;
    logic         pc;
    int           n;
    int           i_acc;

    rst      = 1'b1;
    in_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    cin      = 1'b0;

    #1;
    check("rst_outs", {a, b, carryin, frame_start, busy}, 5'b00000);
    check("rst_frames", frames_sent, 8'd0);
    check("rst_ready", in_ready, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single directed frame.
    cycle(1'b1, 4'b1011, 4'b0110, 1'b1, acc);
    repeat (7) cycle(1'b0, '0, '0, 1'b0, acc);
    check("t034_frames", frames_sent, 8'd1);

    // Three back-to-back frames with valid held high.
    pa = W'($urandom); pb = W'($urandom); pc = 1'($urandom);
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      cycle(1'b1, pa, pb, pc, acc);
      if (acc) begin
        n++;
        pa = W'($urandom); pb = W'($urandom); pc = 1'($urandom);
      end
    end
    check("t035_accepts", n, 3);
    repeat (8) cycle(1'b0, '0, '0, 1'b0, acc);
    check("t035_frames", frames_sent, 8'd4);

    // Offer during SHIFT is ignored until the final gap slot.
    cycle(1'b1, 4'h3, 4'h5, 1'b0, acc);
    i_acc = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 4'hF, 4'hA, 1'b1, acc);
      if (acc && i_acc < 0) i_acc = i;
      if (acc) break;
    end
    check("t036_accept_slot", i_acc, W + G - 1);
    repeat (8) cycle(1'b0, '0, '0, 1'b0, acc);

    // Asynchronous reset on the second data bit.
    do_reset();
    cycle(1'b1, 4'hC, 4'h3, 1'b1, acc);
    cycle(1'b0, '0, '0, 1'b0, acc);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    mdl_rem    = 0;
    mdl_frames = 8'd0;
    mdl_carry  = 1'b0;
    #1;
    check("t037_outs", {a, b, carryin, frame_start, busy}, 5'b00000);
    check("t037_frames", frames_sent, 8'd0);
    check("t037_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) cycle(1'b0, '0, '0, 1'b0, acc);

    // Random traffic; operands held until accepted.
    pa = W'($urandom); pb = W'($urandom); pc = 1'($urandom);
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, pa, pb, pc, acc);
      if (acc) begin
        pa = W'($urandom); pb = W'($urandom); pc = 1'($urandom);
      end
    end
    repeat (8) cycle(1'b0, '0, '0, 1'b0, acc);

    // Counter wrap: 255 frames, then one more.
    do_reset();
    n = 0;
    for (int i = 0; i < 2000 && n < 255; i++) begin
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), acc);
      if (acc) n++;
    end
    repeat (8) cycle(1'b0, '0, '0, 1'b0, acc);
    check("t038_255", frames_sent, 8'd255);
    cycle(1'b1, 4'h9, 4'h6, 1'b0, acc);
    repeat (8) cycle(1'b0, '0, '0, 1'b0, acc);
    check("t038_wrap", frames_sent, 8'd0);

    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
